// File: rtl/stage4_mem_ctrl.sv
// MEM stage: PC redirect with return-address stack, req/ack data-memory access
// with pipeline stall, and MEM/WB pipeline registers.
module stage4_mem_ctrl #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PC_W      = 12,
  parameter int unsigned RAS_DEPTH = 8,
  parameter int unsigned REG_AW    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              BR_Ex,
  input  logic              JMP_flag,
  input  logic              CALL_flag,
  input  logic              RET_flag,
  input  logic [15:0]       imm,
  input  logic [PC_W-1:0]   return_PC,
  input  logic              Memory_Read,
  input  logic              Memory_Write,
  input  logic [DATA_W-1:0] Result,
  input  logic [DATA_W-1:0] data1,
  input  logic [REG_AW-1:0] Addr_Write_Reg_in,
  input  logic              Reg_Write_En_in,
  input  logic              WB_Mux_sel_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              BR_JMP_Ex,
  output logic [PC_W-1:0]   next_PC,
  output logic [DATA_W-1:0] Result_out,
  output logic [DATA_W-1:0] Memory_Data,
  output logic [REG_AW-1:0] Addr_Write_Reg_out,
  output logic              Reg_Write_En_out,
  output logic              WB_Mux_sel_out,
  output logic              ras_overflow,
  output logic              ras_underflow
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t              state, state_nxt;
  logic                req_nxt, we_nxt;
  logic [DATA_W-1:0]   addr_nxt, wdata_nxt;
  logic [PC_W-1:0]     ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]    ras_ptr, top_ptr;
  logic [CNT_W-1:0]    ras_cnt;
  logic                advance, ras_empty, ras_full;
  logic                do_ret, do_call, do_jmp, is_load;

  // Memory handshake FSM: next state, next request fields and stall
  always_comb begin
    state_nxt = state;
    req_nxt   = mem_req;
    we_nxt    = mem_we;
    addr_nxt  = mem_addr;
    wdata_nxt = mem_wdata;
    stall     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Memory_Read || Memory_Write) begin
          stall     = 1'b1;
          state_nxt = ST_WAIT;
          req_nxt   = 1'b1;
          we_nxt    = Memory_Write;
          addr_nxt  = Result;
          wdata_nxt = data1;
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          state_nxt = ST_IDLE;
          req_nxt   = 1'b0;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nxt;
      mem_req   <= req_nxt;
      mem_we    <= we_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
    end
  end

  // Redirect decode, only on advance edges; RET > CALL > JMP > BR
  always_comb begin
    advance   = ~stall;
    do_ret    = advance & RET_flag;
    do_call   = advance & CALL_flag & ~RET_flag;
    do_jmp    = advance & (JMP_flag | BR_Ex) & ~RET_flag & ~CALL_flag;
    ras_empty = (ras_cnt == '0);
    ras_full  = (ras_cnt == CNT_W'(RAS_DEPTH));
    top_ptr   = ras_ptr - PTR_W'(1);
    is_load   = Memory_Read & ~Memory_Write;
  end

  // Stack storage needs no reset; validity is tracked by ras_cnt
  always_ff @(posedge clk) begin
    if (do_call) ras_mem[ras_ptr] <= return_PC;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ras_ptr       <= '0;
      ras_cnt       <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
      BR_JMP_Ex     <= 1'b0;
      next_PC       <= '0;
    end else begin
      BR_JMP_Ex <= do_ret | do_call | do_jmp;
      if (do_ret) begin
        if (ras_empty) begin
          next_PC       <= '0;
          ras_underflow <= 1'b1;
        end else begin
          next_PC <= ras_mem[top_ptr];
          ras_ptr <= top_ptr;
          ras_cnt <= ras_cnt - CNT_W'(1);
        end
      end else if (do_call || do_jmp) begin
        next_PC <= imm[PC_W-1:0];
      end
      if (do_call) begin
        ras_ptr <= ras_ptr + PTR_W'(1);
        if (ras_full) ras_overflow <= 1'b1;
        else          ras_cnt      <= ras_cnt + CNT_W'(1);
      end
    end
  end

  // MEM/WB registers; a stalled edge inserts a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Result_out         <= '0;
      Memory_Data        <= '0;
      Addr_Write_Reg_out <= '0;
      Reg_Write_En_out   <= 1'b0;
      WB_Mux_sel_out     <= 1'b0;
    end else if (advance) begin
      Result_out         <= Result;
      Addr_Write_Reg_out <= Addr_Write_Reg_in;
      Reg_Write_En_out   <= Reg_Write_En_in;
      WB_Mux_sel_out     <= WB_Mux_sel_in;
      if (is_load) Memory_Data <= mem_rdata;
    end else begin
      Reg_Write_En_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stage4_mem_ctrl.sv
// Directed self-checking bench for stage4_mem_ctrl: vector table for
// single-cycle redirects plus hand sequences for RAS, memory and reset cases.
module tb_stage4_mem_ctrl;

  logic        clk, reset;
  logic        BR_Ex, JMP_flag, CALL_flag, RET_flag;
  logic [15:0] imm;
  logic [11:0] return_PC;
  logic        Memory_Read, Memory_Write;
  logic [31:0] Result, data1;
  logic [4:0]  Addr_Write_Reg_in;
  logic        Reg_Write_En_in, WB_Mux_sel_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack, stall, BR_JMP_Ex;
  logic [11:0] next_PC;
  logic [31:0] Result_out, Memory_Data;
  logic [4:0]  Addr_Write_Reg_out;
  logic        Reg_Write_En_out, WB_Mux_sel_out, ras_overflow, ras_underflow;

  int n_vec = 0;
  int n_miss = 0;

  stage4_mem_ctrl #(.DATA_W(32), .PC_W(12), .RAS_DEPTH(8), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .BR_Ex(BR_Ex), .JMP_flag(JMP_flag),
    .CALL_flag(CALL_flag), .RET_flag(RET_flag), .imm(imm), .return_PC(return_PC),
    .Memory_Read(Memory_Read), .Memory_Write(Memory_Write), .Result(Result),
    .data1(data1), .Addr_Write_Reg_in(Addr_Write_Reg_in),
    .Reg_Write_En_in(Reg_Write_En_in), .WB_Mux_sel_in(WB_Mux_sel_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
    .BR_JMP_Ex(BR_JMP_Ex), .next_PC(next_PC), .Result_out(Result_out),
    .Memory_Data(Memory_Data), .Addr_Write_Reg_out(Addr_Write_Reg_out),
    .Reg_Write_En_out(Reg_Write_En_out), .WB_Mux_sel_out(WB_Mux_sel_out),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        br, jmp, call, ret;
    logic [15:0] imm;
    logic [11:0] rpc;
    logic [31:0] res;
    logic [4:0]  wa;
    logic        rwe, wbs;
    logic        e_br;
    logic [11:0] e_pc;
    logic        e_unf;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    BR_Ex = 0; JMP_flag = 0; CALL_flag = 0; RET_flag = 0; imm = '0; return_PC = '0;
    Memory_Read = 0; Memory_Write = 0; Result = '0; data1 = '0;
    Addr_Write_Reg_in = '0; Reg_Write_En_in = 0; WB_Mux_sel_in = 0;
    mem_rdata = '0; mem_ack = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    reset = 0;
    clear_inputs();

    // redirect / priority / RAS table: inputs for one cycle, outputs after the edge
    vecs[0]  = '{1,0,0,0,16'h0009,12'h000,32'h11,5'd1,1,0, 1,12'h009,0};
    vecs[1]  = '{0,0,0,0,16'h0000,12'h000,32'h22,5'd2,0,1, 0,12'h009,0};
    vecs[2]  = '{1,1,0,0,16'h002A,12'h000,32'h33,5'd3,1,1, 1,12'h02A,0};
    vecs[3]  = '{0,0,0,0,16'h0000,12'h000,32'h44,5'd4,1,0, 0,12'h02A,0};
    vecs[4]  = '{0,0,1,0,16'h0100,12'h055,32'h55,5'd5,0,0, 1,12'h100,0};
    vecs[5]  = '{0,0,1,1,16'h0003,12'h077,32'h66,5'd6,1,1, 1,12'h055,0};
    vecs[6]  = '{0,0,0,0,16'h0000,12'h000,32'h1234,5'd7,1,1, 0,12'h055,0};
    vecs[7]  = '{0,0,1,0,16'h0020,12'h011,32'h77,5'd8,0,0, 1,12'h020,0};
    vecs[8]  = '{0,1,1,0,16'h0030,12'h022,32'h88,5'd9,1,0, 1,12'h030,0};
    vecs[9]  = '{1,0,0,1,16'h0005,12'h000,32'h99,5'd10,1,1, 1,12'h022,0};
    vecs[10] = '{0,0,0,1,16'h0000,12'h000,32'hAA,5'd11,0,1, 1,12'h011,0};
    vecs[11] = '{0,0,0,1,16'h0000,12'h000,32'hBB,5'd12,1,0, 1,12'h000,1};
    vecs[12] = '{0,1,0,0,16'hFFFF,12'h000,32'hCC,5'd31,1,1, 1,12'hFFF,1};

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst mem_req", 64'(mem_req), 64'd0);
    chk("rst mem_we", 64'(mem_we), 64'd0);
    chk("rst mem_addr", 64'(mem_addr), 64'd0);
    chk("rst mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst stall", 64'(stall), 64'd0);
    chk("rst BR_JMP_Ex", 64'(BR_JMP_Ex), 64'd0);
    chk("rst next_PC", 64'(next_PC), 64'd0);
    chk("rst Result_out", 64'(Result_out), 64'd0);
    chk("rst Memory_Data", 64'(Memory_Data), 64'd0);
    chk("rst Addr_Write_Reg_out", 64'(Addr_Write_Reg_out), 64'd0);
    chk("rst Reg_Write_En_out", 64'(Reg_Write_En_out), 64'd0);
    chk("rst WB_Mux_sel_out", 64'(WB_Mux_sel_out), 64'd0);
    chk("rst flags", 64'({ras_overflow, ras_underflow}), 64'd0);
    reset = 1;

    for (int i = 0; i < 13; i++) begin
      BR_Ex = vecs[i].br; JMP_flag = vecs[i].jmp; CALL_flag = vecs[i].call;
      RET_flag = vecs[i].ret; imm = vecs[i].imm; return_PC = vecs[i].rpc;
      Result = vecs[i].res; Addr_Write_Reg_in = vecs[i].wa;
      Reg_Write_En_in = vecs[i].rwe; WB_Mux_sel_in = vecs[i].wbs;
      @(negedge clk);
      chk($sformatf("v%0d BR_JMP_Ex", i), 64'(BR_JMP_Ex), 64'(vecs[i].e_br));
      chk($sformatf("v%0d next_PC", i), 64'(next_PC), 64'(vecs[i].e_pc));
      chk($sformatf("v%0d Result_out", i), 64'(Result_out), 64'(vecs[i].res));
      chk($sformatf("v%0d Addr_Write_Reg_out", i), 64'(Addr_Write_Reg_out), 64'(vecs[i].wa));
      chk($sformatf("v%0d Reg_Write_En_out", i), 64'(Reg_Write_En_out), 64'(vecs[i].rwe));
      chk($sformatf("v%0d WB_Mux_sel_out", i), 64'(WB_Mux_sel_out), 64'(vecs[i].wbs));
      chk($sformatf("v%0d ras_underflow", i), 64'(ras_underflow), 64'(vecs[i].e_unf));
      chk($sformatf("v%0d ras_overflow", i), 64'(ras_overflow), 64'd0);
    end

    // RAS overflow: push 1..9 into 8 entries, then pop 9 down to 2
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      CALL_flag = 1; return_PC = 12'(i); imm = 16'(i + 100);
      @(negedge clk);
      chk($sformatf("push%0d next_PC", i), 64'(next_PC), 64'(i + 100));
    end
    CALL_flag = 0;
    chk("ras overflow set", 64'(ras_overflow), 64'd1);
    for (int i = 9; i >= 2; i--) begin
      RET_flag = 1;
      @(negedge clk);
      chk($sformatf("pop%0d next_PC", i), 64'(next_PC), 64'(i));
      chk($sformatf("pop%0d BR_JMP_Ex", i), 64'(BR_JMP_Ex), 64'd1);
    end
    RET_flag = 0;
    chk("ras no underflow", 64'(ras_underflow), 64'd0);
    chk("ras overflow sticky", 64'(ras_overflow), 64'd1);

    // Underflow after fresh reset
    do_reset();
    RET_flag = 1; imm = 16'h0123;
    @(negedge clk);
    RET_flag = 0;
    chk("unf next_PC", 64'(next_PC), 64'd0);
    chk("unf BR_JMP_Ex", 64'(BR_JMP_Ex), 64'd1);
    chk("unf flag", 64'(ras_underflow), 64'd1);
    @(negedge clk);
    chk("unf pulse end", 64'(BR_JMP_Ex), 64'd0);

    // Load with ack arriving in the third request cycle
    do_reset();
    Memory_Read = 1; Result = 32'h40; Reg_Write_En_in = 1; Addr_Write_Reg_in = 5'd3;
    #1 chk("ld stall idle", 64'(stall), 64'd1);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      chk($sformatf("ld c%0d mem_req", c), 64'(mem_req), 64'd1);
      chk($sformatf("ld c%0d mem_addr", c), 64'(mem_addr), 64'h40);
      chk($sformatf("ld c%0d mem_we", c), 64'(mem_we), 64'd0);
      chk($sformatf("ld c%0d stall", c), 64'(stall), 64'd1);
      chk($sformatf("ld c%0d Reg_Write_En_out", c), 64'(Reg_Write_En_out), 64'd0);
    end
    @(negedge clk);
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    #1 chk("ld ack stall", 64'(stall), 64'd0);
    chk("ld ack mem_req", 64'(mem_req), 64'd1);
    @(negedge clk);
    clear_inputs();
    chk("ld done mem_req", 64'(mem_req), 64'd0);
    chk("ld Memory_Data", 64'(Memory_Data), 64'hDEADBEEF);
    chk("ld Reg_Write_En_out", 64'(Reg_Write_En_out), 64'd1);
    chk("ld Result_out", 64'(Result_out), 64'h40);
    chk("ld Addr_Write_Reg_out", 64'(Addr_Write_Reg_out), 64'd3);
    @(negedge clk);
    chk("ld data holds", 64'(Memory_Data), 64'hDEADBEEF);

    // Store combined with CALL: one push, in the ack cycle
    do_reset();
    Memory_Write = 1; data1 = 32'h1234; Result = 32'h80;
    CALL_flag = 1; return_PC = 12'h010; imm = 16'h0200;
    @(negedge clk);
    chk("st mem_req", 64'(mem_req), 64'd1);
    chk("st mem_we", 64'(mem_we), 64'd1);
    chk("st mem_wdata", 64'(mem_wdata), 64'h1234);
    chk("st no redirect yet", 64'(BR_JMP_Ex), 64'd0);
    @(negedge clk);
    chk("st wait redirect", 64'(BR_JMP_Ex), 64'd0);
    mem_ack = 1;
    @(negedge clk);
    clear_inputs();
    chk("st redirect", 64'(BR_JMP_Ex), 64'd1);
    chk("st next_PC", 64'(next_PC), 64'h200);
    chk("st mem_req drop", 64'(mem_req), 64'd0);
    RET_flag = 1;
    @(negedge clk);
    chk("st ret next_PC", 64'(next_PC), 64'h010);
    chk("st ret underflow", 64'(ras_underflow), 64'd0);
    @(negedge clk);
    RET_flag = 0;
    chk("st single push", 64'(ras_underflow), 64'd1);

    // Reset in the middle of a pending access, then a stray ack
    do_reset();
    Memory_Read = 1; Result = 32'h99; Reg_Write_En_in = 1;
    @(negedge clk);
    chk("rw mem_req", 64'(mem_req), 64'd1);
    clear_inputs();
    reset = 0;
    #1 chk("rw async drop", 64'(mem_req), 64'd0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    mem_ack = 1; mem_rdata = 32'hCAFE;
    #1 chk("rw stray stall", 64'(stall), 64'd0);
    @(negedge clk);
    mem_ack = 0;
    chk("rw Memory_Data", 64'(Memory_Data), 64'd0);
    chk("rw Reg_Write_En_out", 64'(Reg_Write_En_out), 64'd0);
    chk("rw Result_out", 64'(Result_out), 64'd0);
    chk("rw mem_req", 64'(mem_req), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
